// File: rtl/a_b_link_arbiter.sv
// a_b_link_arbiter: round-robin owner of the module_b -> module_a link.
// One request in flight; reply or timeout is routed back to its owner.
module a_b_link_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_TO_A_BITWIDTH = 16,
  parameter int DATA_FROM_A_BITWIDTH = 16,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ*DATA_TO_A_BITWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [DATA_TO_A_BITWIDTH-1:0] data_to_a,
  output logic to_a_valid,
  input  logic to_a_ready,
  input  logic [DATA_FROM_A_BITWIDTH-1:0] data_from_a,
  input  logic from_a_valid,
  output logic [DATA_FROM_A_BITWIDTH-1:0] resp_data,
  output logic [NUM_REQ-1:0] resp_valid,
  output logic [NUM_REQ-1:0] resp_timeout,
  output logic [GW-1:0] grant_id,
  output logic busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_t;

  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] LAST_INIT =
    GW'(NUM_REQ - 1);

  state_t state;
  logic [GW-1:0] last_grant;
  logic [CW-1:0] cnt;
  logic [GW-1:0] sel;
  logic [GW-1:0] hi_sel;
  logic [GW-1:0] lo_sel;
  logic hi_found;
  logic lo_found;
  logic found;

  // Lowest index above last_grant wins; otherwise wrap to lowest overall.
  always_comb begin
    hi_sel = '0;
    lo_sel = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i > int'(last_grant)) begin
          hi_found = 1'b1;
          hi_sel = GW'(i);
        end else begin
          lo_found = 1'b1;
          lo_sel = GW'(i);
        end
      end
    end
    found = hi_found | lo_found;
    sel = hi_found ? hi_sel : lo_sel;
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && rst_n && found)
      req_ready[sel] = 1'b1;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      last_grant <= LAST_INIT;
      cnt <= '0;
      data_to_a <= '0;
      to_a_valid <= 1'b0;
      resp_data <= '0;
      resp_valid <= '0;
      resp_timeout <= '0;
      grant_id <= '0;
    end else begin
      resp_valid <= '0;
      resp_timeout <= '0;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            data_to_a <= req_data[int'(sel)*DATA_TO_A_BITWIDTH
                                  +: DATA_TO_A_BITWIDTH];
            grant_id <= sel;
            last_grant <= sel;
            to_a_valid <= 1'b1;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (to_a_ready) begin
            to_a_valid <= 1'b0;
            cnt <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A reply in the terminal cycle takes priority over timeout.
          if (from_a_valid) begin
            resp_data <= data_from_a;
            resp_valid[grant_id] <= 1'b1;
            state <= S_IDLE;
          end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
            resp_timeout[grant_id] <= 1'b1;
            state <= S_IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a_b_link_arbiter.sv
// tb_a_b_link_arbiter: directed + random stimulus against a
// transaction-level reference model, checked every cycle.
module tb_a_b_link_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int RW = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [N-1:0] req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0] req_ready;
  logic [DW-1:0] data_to_a;
  logic to_a_valid;
  logic to_a_ready;
  logic [RW-1:0] data_from_a;
  logic from_a_valid;
  logic [RW-1:0] resp_data;
  logic [N-1:0] resp_valid;
  logic [N-1:0] resp_timeout;
  logic [1:0] grant_id;
  logic busy;

  a_b_link_arbiter #(
    .NUM_REQ(N),
    .DATA_TO_A_BITWIDTH(DW),
    .DATA_FROM_A_BITWIDTH(RW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .data_to_a(data_to_a),
    .to_a_valid(to_a_valid),
    .to_a_ready(to_a_ready),
    .data_from_a(data_from_a),
    .from_a_valid(from_a_valid),
    .resp_data(resp_data),
    .resp_valid(resp_valid),
    .resp_timeout(resp_timeout),
    .grant_id(grant_id),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: one in-flight record plus the last owner.
  bit m_active;
  bit m_sent;
  int m_owner;
  int m_last;
  int m_grant;
  int m_waited;
  logic [DW-1:0] m_word;
  logic [RW-1:0] m_rdata;
  logic [N-1:0] m_rv;
  logic [N-1:0] m_rt;
  int grants[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_active = 0;
    m_sent = 0;
    m_owner = 0;
    m_last = N - 1;
    m_grant = 0;
    m_waited = 0;
    m_word = '0;
    m_rdata = '0;
    m_rv = '0;
    m_rt = '0;
  endfunction

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic void model_step();
    int p;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_rv = '0;
    m_rt = '0;
    if (!m_active) begin
      p = pick();
      if (p >= 0) begin
        m_active = 1;
        m_sent = 0;
        m_owner = p;
        m_grant = p;
        m_last = p;
        m_word = req_data[p*DW +: DW];
        grants.push_back(p);
      end
    end else if (!m_sent) begin
      if (to_a_ready) begin
        m_sent = 1;
        m_waited = 0;
      end
    end else begin
      m_waited++;
      if (from_a_valid) begin
        m_rdata = data_from_a;
        m_rv[m_owner] = 1'b1;
        m_active = 0;
      end else if (m_waited == TO) begin
        m_rt[m_owner] = 1'b1;
        m_active = 0;
      end
    end
  endfunction

  // One clock: check the combinational accept, advance, check registers.
  task automatic cycle();
    logic [N-1:0] er;
    int p;
    #1;
    er = '0;
    p = pick();
    if (!m_active && rst_n && p >= 0) er[p] = 1'b1;
    chk("req_ready", req_ready, er);
    model_step();
    @(posedge clk);
    #1;
    chk("to_a_valid", to_a_valid, m_active && !m_sent);
    chk("data_to_a", data_to_a, m_word);
    chk("busy", busy, m_active);
    chk("resp_valid", resp_valid, m_rv);
    chk("resp_timeout", resp_timeout, m_rt);
    chk("resp_data", resp_data, m_rdata);
    chk("grant_id", grant_id, m_grant);
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0;
    to_a_ready = 1'b1;
    from_a_valid = 1'b1;
    data_from_a = 16'(($urandom));
    while (m_active && n < 20) begin
      cycle();
      n++;
    end
    chk("drain_idle", m_active, 0);
    to_a_ready = 1'b0;
    from_a_valid = 1'b0;
  endtask

  initial begin
    int n;
    int exp_a[5];
    int exp_b[4];
    exp_a = '{0, 1, 2, 3, 0};
    exp_b = '{2, 3, 0, 2};

    rst_n = 1'b0;
    req_valid = '1;
    req_data = '0;
    to_a_ready = 1'b0;
    from_a_valid = 1'b0;
    data_from_a = '0;
    model_reset();
    @(posedge clk);

    repeat (3) cycle();
    chk("rst_ready", req_ready, 0);
    chk("rst_to_a_valid", to_a_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    cycle();
    chk("first_grant", grant_id, 0);
    chk("first_send", to_a_valid, 1);
    drain();

    // single transaction on requester 2
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 16'h1234;
    cycle();
    chk("single_word", data_to_a, 16'h1234);
    req_valid = '0;
    to_a_ready = 1'b1;
    cycle();
    chk("single_sent", to_a_valid, 0);
    to_a_ready = 1'b0;
    from_a_valid = 1'b1;
    data_from_a = 16'hBEEF;
    cycle();
    from_a_valid = 1'b0;
    chk("single_rv", resp_valid, 4'b0100);
    chk("single_rd", resp_data, 16'hBEEF);
    chk("single_idle", busy, 0);

    // round robin from reset, then with requester 1 withdrawn
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    grants.delete();
    req_valid = 4'hF;
    to_a_ready = 1'b1;
    from_a_valid = 1'b1;
    repeat (15) cycle();
    chk("rr_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk("rr_order", grants[i], exp_a[i]);
    grants.delete();
    req_valid = 4'b1101;
    repeat (12) cycle();
    chk("rr2_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk("rr2_order", grants[i], exp_b[i]);
    drain();

    // backpressure in SEND, then timeout in WAIT
    req_valid = 4'b0001;
    req_data[0 +: DW] = 16'hA5A5;
    cycle();
    req_valid = '0;
    to_a_ready = 1'b0;
    from_a_valid = 1'b1;
    repeat (10) cycle();
    chk("bp_word", data_to_a, 16'hA5A5);
    chk("bp_valid", to_a_valid, 1);
    chk("bp_busy", busy, 1);
    chk("bp_no_to", resp_timeout, 0);
    from_a_valid = 1'b0;
    to_a_ready = 1'b1;
    cycle();
    to_a_ready = 1'b0;
    n = 0;
    while (resp_timeout == '0 && n < 30) begin
      cycle();
      n++;
    end
    chk("to_latency", n, 8);
    chk("to_strobe", resp_timeout, 4'b0001);
    from_a_valid = 1'b1;
    repeat (2) cycle();
    chk("late_ignored", resp_valid, 0);
    from_a_valid = 1'b0;

    // reply in the terminal timeout cycle
    req_valid = 4'b0010;
    cycle();
    req_valid = '0;
    to_a_ready = 1'b1;
    cycle();
    to_a_ready = 1'b0;
    repeat (7) cycle();
    from_a_valid = 1'b1;
    data_from_a = 16'h7E57;
    cycle();
    from_a_valid = 1'b0;
    chk("edge_rv", resp_valid, 4'b0010);
    chk("edge_no_to", resp_timeout, 0);
    chk("edge_rd", resp_data, 16'h7E57);

    // reset while waiting
    req_valid = 4'b1000;
    cycle();
    req_valid = '0;
    to_a_ready = 1'b1;
    cycle();
    to_a_ready = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b0;
    cycle();
    chk("midrst_busy", busy, 0);
    chk("midrst_rv", resp_valid, 0);
    chk("midrst_grant", grant_id, 0);
    rst_n = 1'b1;
    req_valid = 4'hF;
    cycle();
    chk("midrst_regrant", grant_id, 0);
    drain();

    // random traffic
    repeat (3000) begin
      rst_n = ($urandom_range(0, 199) != 0);
      req_valid = N'($urandom);
      req_data = {$urandom, $urandom};
      to_a_ready = ($urandom_range(0, 9) < 7);
      from_a_valid = ($urandom_range(0, 3) == 0);
      data_from_a = RW'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
